reversi_accel_div_26ns_16ns: RTL and testbench
==============================================

# reversi_accel_div_26ns_16ns

Iterative radix-2 restoring divider that undoes the accelerator's 16×16→26-bit multiplier. It recovers quotient and remainder from a 26-bit unsigned product-domain value and a 16-bit unsigned divisor. It sits next to the multiplier in the accelerator datapath and is driven by the same HLS-style controller, using a start/done handshake and the shared `ce` stall. Latency is fixed at 27 enabled cycles, including divide-by-zero, so the scheduler can treat it as a constant-latency operator.

## Interface
- `DIVIDEND_W`, default 26: dividend and quotient width.
- `DIVISOR_W`, default 16: divisor and remainder width.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `ce`  in  1  clock enable. When low, all state, including `done`, holds.
- `start`  in  1  request. Sampled only when `ce`=1 and the FSM is in IDLE or DONE.
- `dividend`  in  DIVIDEND_W  unsigned dividend. Sampled with `start`.
- `divisor`  in  DIVISOR_W  unsigned divisor. Sampled with `start`.
- `busy`  out  1  high while in CALC.
- `done`  out  1  high for exactly one enabled cycle (DONE state).
- `quot`  out  DIVIDEND_W  quotient register. Valid from `done` until the next accepted `start`.
- `rem`  out  DIVISOR_W  remainder register. Same validity as `quot`.
- `div_zero`  out  1  sticky with `quot`/`rem`. Set when the latched divisor is 0.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: on `start` (with `ce`), latch operands, clear the partial remainder (DIVISOR_W+1 bits), load `cnt`=DIVIDEND_W, and go to CALC. Set `div_zero` = (`divisor`==0).
- CALC, one iteration per enabled cycle:
  - Shift {partial, dividend} left by 1.
  - Trial = partial − divisor (DIVISOR_W+1 bits).
  - If trial ≥ 0, partial ← trial and the new quotient LSB = 1. Otherwise the LSB = 0.
  - Decrement `cnt`. When `cnt` reaches 1 on this iteration, go to DONE.
- DONE:
  - `done`=1. Write `quot` and `rem` from the working registers.
  - If `div_zero`, force `quot`=all ones and `rem`=`dividend[DIVISOR_W-1:0]` as latched.
  - Next state is CALC if `start` is present (back-to-back, operands latched as in IDLE), otherwise IDLE.
- `start` during CALC is ignored. Operands are not re-sampled.
- Reset value of every output is 0: `busy`, `done`, `quot`, `rem`, `div_zero`. FSM resets to IDLE. Reset mid-CALC aborts the operation with no `done`.
- Widths:
  - Partial remainder is DIVISOR_W+1 bits, so there is no overflow at divisor=0xFFFF.
  - The final partial remainder is always < divisor and fits DIVISOR_W bits.

## Timing
- `start` accepted at enabled cycle T.
- CALC occupies T+1..T+26 with `busy`=1.
- DONE at T+27: `done`=1, and `quot`/`rem` are updated at the same edge that enters DONE.
- Latency is counted in `ce`=1 cycles only. A `ce`=0 cycle stretches every phase and holds `done` high if it is already high.
- Back-to-back: `start` in DONE gives the next `done` exactly 27 enabled cycles later, for a throughput of 1 operation per 27 cycles.
- `quot`/`rem` change only on the edge entering DONE or on reset.

## Structure
- Shared package `reversi_accel_div_pkg` holds:
  - `DIV_DIVIDEND_W`=26 and `DIV_DIVISOR_W`=16.
  - State enum `div_state_t` {IDLE, CALC, DONE}.
  - Counter width `DIV_CNT_W`=$clog2(26+1).
- One natural sub-module: `reversi_accel_div_step`. It is the combinational single-iteration shift/trial-subtract, taking partial, dividend MSB, and divisor, and returning the next partial and the quotient bit. The top module owns the FSM, counter and registers.

## Test plan
- 1000 / 7, `ce`=1 throughout → `done` at T+27, `quot`=142, `rem`=6, `div_zero`=0. `busy` high for 26 cycles.
- 0x3FFFFFF / 0xFFFF → `quot`=0x400, `rem`=0x3FF. Also 0x3FFFC00 / 0x400 → `quot`=0xFFFF, `rem`=0, which round-trips the multiplier.
- 5 / 0 → `done` at T+27, `quot`=0x3FFFFFF, `rem`=5, `div_zero`=1. A following 10 / 3 clears `div_zero`: `quot`=3, `rem`=1.
- 1000 / 7 with `ce` low for 5 random cycles mid-CALC and 2 cycles during DONE → `done` at T+32, held for 3 clocks, same results. A second `start` (9 / 2) asserted during CALC is ignored.
- Back-to-back: `start` held through DONE with 100 / 9, then 26 / 5 → `done` pulses 27 enabled cycles apart, with results (11,1) then (5,1).
- Assert `reset` asynchronously (between edges) at T+10 → all outputs 0 immediately, FSM in IDLE, and no `done` appears. The next `start` completes normally.

Source files
------------

// File: rtl/reversi_accel_div_26ns_16ns_pkg.sv
// Shared types and widths for the reversi accelerator divider.
// Imported by the divider top and its iteration step.
package reversi_accel_div_pkg;

    localparam int DIV_DIVIDEND_W = 26;
    localparam int DIV_DIVISOR_W  = 16;
    localparam int DIV_CNT_W      = $clog2(DIV_DIVIDEND_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

endpackage

// File: rtl/reversi_accel_div_26ns_16ns_if.sv
// Start/done bus between the HLS controller and the divider.
// The controller is the master; the divider is the slave.
interface reversi_accel_div_26ns_16ns_if #(
    parameter int DIVIDEND_W = 26,
    parameter int DIVISOR_W  = 16
);

    logic                  ce;
    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  busy;
    logic                  done;
    logic [DIVIDEND_W-1:0] quot;
    logic [DIVISOR_W-1:0]  rem;
    logic                  div_zero;

    modport master (
        output ce, start, dividend, divisor,
        input  busy, done, quot, rem, div_zero
    );

    modport slave (
        input  ce, start, dividend, divisor,
        output busy, done, quot, rem, div_zero
    );

endinterface

// File: rtl/reversi_accel_div_26ns_16ns_step.sv
// One restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor, keep the result if non-negative.
module reversi_accel_div_step
    import reversi_accel_div_pkg::*;
#(
    parameter int DIVISOR_W = DIV_DIVISOR_W
) (
    input  logic [DIVISOR_W:0]   partial,
    input  logic                 msb,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   next_partial,
    output logic                 qbit
);

    logic [DIVISOR_W+1:0] shifted;
    logic [DIVISOR_W:0]   trial;

    // Shift, trial-subtract and restore on a negative result
    always_comb begin
        shifted      = {partial, msb};
        trial        = shifted[DIVISOR_W:0] - {1'b0, divisor};
        qbit         = (shifted >= {2'b00, divisor});
        next_partial = qbit ? trial : shifted[DIVISOR_W:0];
    end

endmodule

// File: rtl/reversi_accel_div_26ns_16ns.sv
// Fixed-latency (27 enabled cycles) restoring divider that
// inverts the accelerator's 16x16 multiplier.
module reversi_accel_div_26ns_16ns
    import reversi_accel_div_pkg::*;
#(
    parameter int DIVIDEND_W = DIV_DIVIDEND_W,
    parameter int DIVISOR_W  = DIV_DIVISOR_W
) (
    input logic clk,
    input logic reset,
    reversi_accel_div_26ns_16ns_if.slave bus
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    div_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIVISOR_W:0]    part_q, part_d;
    logic [DIVIDEND_W-1:0] dq_q, dq_d;
    logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
    logic [DIVISOR_W-1:0]  dvd_lo_q, dvd_lo_d;
    logic [DIVIDEND_W-1:0] quot_q, quot_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic                  dz_q, dz_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [DIVISOR_W:0]    step_part;
    logic                  step_qbit;

    reversi_accel_div_step #(
        .DIVISOR_W(DIVISOR_W)
    ) u_step (
        .partial     (part_q),
        .msb         (dq_q[DIVIDEND_W-1]),
        .divisor     (dsr_q),
        .next_partial(step_part),
        .qbit        (step_qbit)
    );

    // Next-state logic; everything holds while ce is low
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        part_d   = part_q;
        dq_d     = dq_q;
        dsr_d    = dsr_q;
        dvd_lo_d = dvd_lo_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        dz_d     = dz_q;
        busy_d   = busy_q;
        done_d   = done_q;
        if (bus.ce) begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_d  = CALC;
                        cnt_d    = CNT_W'(DIVIDEND_W);
                        part_d   = '0;
                        dq_d     = bus.dividend;
                        dsr_d    = bus.divisor;
                        dvd_lo_d = bus.dividend[DIVISOR_W-1:0];
                        dz_d     = (bus.divisor == '0);
                    end else begin
                        state_d = IDLE;
                    end
                end
                CALC: begin
                    part_d = step_part;
                    dq_d   = {dq_q[DIVIDEND_W-2:0], step_qbit};
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                        quot_d  = dz_q ? '1 :
                                  {dq_q[DIVIDEND_W-2:0], step_qbit};
                        rem_d   = dz_q ? dvd_lo_q :
                                  step_part[DIVISOR_W-1:0];
                    end
                end
                default: state_d = IDLE;
            endcase
            busy_d = (state_d == CALC);
            done_d = (state_d == DONE);
        end
    end

    // State and registered outputs, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            part_q   <= '0;
            dq_q     <= '0;
            dsr_q    <= '0;
            dvd_lo_q <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            part_q   <= part_d;
            dq_q     <= dq_d;
            dsr_q    <= dsr_d;
            dvd_lo_q <= dvd_lo_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            dz_q     <= dz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.quot     = quot_q;
    assign bus.rem      = rem_q;
    assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_reversi_accel_div_26ns_16ns.sv
// Directed-vector bench for the 26/16 restoring divider.
// Latency is counted in edges from the accepting edge to done.
module tb_reversi_accel_div_26ns_16ns;

    logic clk;
    logic reset;
    int   pass_cnt;
    int   total;

    reversi_accel_div_26ns_16ns_if #(
        .DIVIDEND_W(26),
        .DIVISOR_W (16)
    ) bus ();

    reversi_accel_div_26ns_16ns dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive start for one accepting edge, then wait for done.
    task automatic run_op(input logic [25:0] a, input logic [15:0] b,
                          output int lat, output int busy_n);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        lat    = 1;
        busy_n = 0;
        while (!bus.done && lat < 200) begin
            if (bus.busy) busy_n++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        bus.ce = 1'b1;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        reset = 1'b1;
        tick();
        tick();
        total++;
        if ({bus.busy, bus.done, bus.div_zero} !== 3'b000)
            $display("FAIL reset_flags got %b want 000",
                     {bus.busy, bus.done, bus.div_zero});
        else pass_cnt++;
        total++;
        if (bus.quot !== 26'd0 || bus.rem !== 16'd0)
            $display("FAIL reset_data got %h/%h want 0/0", bus.quot, bus.rem);
        else pass_cnt++;
        #2 reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat, bn;
        run_op(26'd1000, 16'd7, lat, bn);
        total++;
        if (lat !== 27) $display("FAIL basic_lat got %0d want 27", lat);
        else pass_cnt++;
        total++;
        if (bn !== 26) $display("FAIL basic_busy got %0d want 26", bn);
        else pass_cnt++;
        total++;
        if (bus.quot !== 26'd142 || bus.rem !== 16'd6 || bus.div_zero !== 1'b0)
            $display("FAIL basic_res got %0d r %0d z %b want 142 r 6 z 0",
                     bus.quot, bus.rem, bus.div_zero);
        else pass_cnt++;
        tick();
        total++;
        if (bus.done !== 1'b0 || bus.quot !== 26'd142)
            $display("FAIL basic_pulse got done %b q %0d want 0 142",
                     bus.done, bus.quot);
        else pass_cnt++;
    endtask

    task automatic test_wide();
        int lat, bn;
        run_op(26'h3FFFFFF, 16'hFFFF, lat, bn);
        total++;
        if (bus.quot !== 26'h400 || bus.rem !== 16'h3FF)
            $display("FAIL wide_max got %h r %h want 400 r 3ff",
                     bus.quot, bus.rem);
        else pass_cnt++;
        run_op(26'h3FFFC00, 16'h400, lat, bn);
        total++;
        if (bus.quot !== 26'hFFFF || bus.rem !== 16'h0)
            $display("FAIL wide_rt got %h r %h want ffff r 0",
                     bus.quot, bus.rem);
        else pass_cnt++;
    endtask

    task automatic test_div_zero();
        int lat, bn;
        run_op(26'd5, 16'd0, lat, bn);
        total++;
        if (lat !== 27) $display("FAIL dz_lat got %0d want 27", lat);
        else pass_cnt++;
        total++;
        if (bus.quot !== 26'h3FFFFFF || bus.rem !== 16'd5 || bus.div_zero !== 1'b1)
            $display("FAIL dz_res got %h r %0d z %b want 3ffffff r 5 z 1",
                     bus.quot, bus.rem, bus.div_zero);
        else pass_cnt++;
        bus.dividend = 26'd10;
        bus.divisor  = 16'd3;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        total++;
        if (bus.quot !== 26'h3FFFFFF || bus.busy !== 1'b1)
            $display("FAIL dz_hold got %h busy %b want 3ffffff 1",
                     bus.quot, bus.busy);
        else pass_cnt++;
        lat = 1;
        while (!bus.done && lat < 200) begin
            tick();
            lat++;
        end
        total++;
        if (lat !== 27 || bus.quot !== 26'd3 || bus.rem !== 16'd1 ||
            bus.div_zero !== 1'b0)
            $display("FAIL dz_next got lat %0d %0d r %0d z %b want 27 3 r 1 z 0",
                     lat, bus.quot, bus.rem, bus.div_zero);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_ce_stall();
        int n;
        bus.dividend = 26'd1000;
        bus.divisor  = 16'd7;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 1;
        while (!bus.done && n < 200) begin
            bus.ce = !(n == 5 || n == 9 || n == 10 || n == 17 || n == 22);
            bus.start = (n >= 8 && n < 12);
            if (bus.start) begin
                bus.dividend = 26'd9;
                bus.divisor  = 16'd2;
            end
            tick();
            n++;
        end
        bus.ce = 1'b1;
        bus.start = 1'b0;
        total++;
        if (n !== 32) $display("FAIL ce_lat got %0d want 32", n);
        else pass_cnt++;
        total++;
        if (bus.quot !== 26'd142 || bus.rem !== 16'd6)
            $display("FAIL ce_res got %0d r %0d want 142 r 6",
                     bus.quot, bus.rem);
        else pass_cnt++;
        bus.ce = 1'b0;
        tick();
        tick();
        total++;
        if (bus.done !== 1'b1)
            $display("FAIL ce_hold got done %b want 1", bus.done);
        else pass_cnt++;
        bus.ce = 1'b1;
        tick();
        total++;
        if (bus.done !== 1'b0)
            $display("FAIL ce_release got done %b want 0", bus.done);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int n, m;
        bus.dividend = 26'd100;
        bus.divisor  = 16'd9;
        bus.start    = 1'b1;
        tick();
        bus.dividend = 26'd26;
        bus.divisor  = 16'd5;
        n = 1;
        while (!bus.done && n < 200) begin
            tick();
            n++;
        end
        total++;
        if (n !== 27 || bus.quot !== 26'd11 || bus.rem !== 16'd1)
            $display("FAIL b2b_first got lat %0d %0d r %0d want 27 11 r 1",
                     n, bus.quot, bus.rem);
        else pass_cnt++;
        tick();
        bus.start = 1'b0;
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1)
            $display("FAIL b2b_accept got done %b busy %b want 0 1",
                     bus.done, bus.busy);
        else pass_cnt++;
        m = 1;
        while (!bus.done && m < 200) begin
            tick();
            m++;
        end
        total++;
        if (m !== 27 || bus.quot !== 26'd5 || bus.rem !== 16'd1)
            $display("FAIL b2b_second got lat %0d %0d r %0d want 27 5 r 1",
                     m, bus.quot, bus.rem);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_async_reset();
        int n, seen, lat, bn;
        bus.dividend = 26'd1000;
        bus.divisor  = 16'd7;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        #2 reset = 1'b1;
        #1;
        total++;
        if ({bus.busy, bus.done, bus.div_zero} !== 3'b000 ||
            bus.quot !== 26'd0 || bus.rem !== 16'd0)
            $display("FAIL areset got b%b d%b z%b q%h r%h want all 0",
                     bus.busy, bus.done, bus.div_zero, bus.quot, bus.rem);
        else pass_cnt++;
        tick();
        #2 reset = 1'b0;
        seen = 0;
        for (n = 0; n < 40; n++) begin
            tick();
            if (bus.done || bus.busy) seen++;
        end
        total++;
        if (seen !== 0)
            $display("FAIL areset_quiet got %0d active cycles want 0", seen);
        else pass_cnt++;
        run_op(26'd10, 16'd3, lat, bn);
        total++;
        if (lat !== 27 || bus.quot !== 26'd3 || bus.rem !== 16'd1)
            $display("FAIL areset_next got lat %0d %0d r %0d want 27 3 r 1",
                     lat, bus.quot, bus.rem);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total    = 0;
        test_reset();
        test_basic();
        test_wide();
        test_div_zero();
        test_ce_stall();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
